mc_residual_gen: RTL

//  Stage directly downstream of the motion-compensation controller.
//  - Takes one 4-pixel row per handshake: the source row, plus the MC prediction row for the same positions.
//  - Forms the signed residual (src - pred) and buffers one full 4x4 block.
//  - Emits the block row by row to the forward transform, with block framing (res_last).

---
 rtl/mc_residual_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mc_residual_gen.sv
// Residual stage: buffers one ROWS x COLS block of (src - pred) and drains it row by row with res_last framing.
// Latency: out valid one cycle after the last row is taken. Fill and drain alternate. Optional SAD behind MC_RES_SAD_EN.
module mc_residual_gen #(
  parameter int PIX_W = 8,
  parameter int COLS  = 4,
  parameter int ROWS  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [COLS*PIX_W-1:0]                src_row,
  input  logic [COLS*PIX_W-1:0]                pred_row,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [COLS*(PIX_W+1)-1:0]            res_row,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic                                 res_last,
  output logic [PIX_W+$clog2(ROWS*COLS)-1:0]   block_sad
);

  localparam int RES_W = PIX_W + 1;
  localparam int SAD_W = PIX_W + $clog2(ROWS*COLS);
  localparam int PTR_W = $clog2(ROWS);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                    state;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          rd_nxt;
  logic [COLS*RES_W-1:0]     row_buf [ROWS];
  logic [COLS*RES_W-1:0]     res_in;
  logic                      in_hs;
  logic                      out_hs;
  logic                      wr_last;
  logic                      rd_last;

  always_comb begin
    res_in = '0;
    for (int i = 0; i < COLS; i++) begin
      res_in[i*RES_W +: RES_W] = {1'b0, src_row[i*PIX_W +: PIX_W]} - {1'b0, pred_row[i*PIX_W +: PIX_W]};
    end
  end

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = res_valid & res_ready;
  assign wr_last = (wr_ptr == PTR_W'(ROWS-1));
  assign rd_last = (rd_ptr == PTR_W'(ROWS-1));
  assign rd_nxt  = rd_ptr + 1'b1;

  // Buffer contents are never visible before being rewritten, so no reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      row_buf[wr_ptr] <= res_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_row   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            if (wr_last) begin
              wr_ptr    <= '0;
              state     <= DRAIN;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              res_row   <= row_buf[0];
              res_last  <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (rd_last) begin
              rd_ptr    <= '0;
              state     <= FILL;
              in_ready  <= 1'b1;
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              res_row   <= '0;
            end else begin
              rd_ptr   <= rd_nxt;
              res_row  <= row_buf[rd_nxt];
              // Row about to be shown is the final one when rd_ptr steps onto ROWS-1.
              res_last <= (rd_ptr == PTR_W'(ROWS-2));
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef MC_RES_SAD_EN
  logic [SAD_W-1:0] row_sad;
  logic [SAD_W-1:0] sad_acc;
  logic [RES_W-1:0] lane_res;

  always_comb begin
    row_sad  = '0;
    lane_res = '0;
    for (int i = 0; i < COLS; i++) begin
      lane_res = res_in[i*RES_W +: RES_W];
      row_sad  = row_sad + SAD_W'(lane_res[RES_W-1] ? (~lane_res + 1'b1) : lane_res);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sad_acc   <= '0;
      block_sad <= '0;
    end else begin
      if (in_hs) begin
        sad_acc <= ((wr_ptr == '0) ? '0 : sad_acc) + row_sad;
      end
      if (in_hs && wr_last) begin
        block_sad <= sad_acc + row_sad;
      end
      if (out_hs && rd_last) begin
        block_sad <= '0;
      end
    end
  end
`else
  assign block_sad = '0;
`endif

endmodule
